// File: rtl/mult_sched.sv
// mult_sched: two-requester scheduler in front of a pipelined multiplier.
// Grants one operand pair per cycle, issues it to the multiplier, and
// writes each product into the winning requester's half of a memory.
// Optional macro MULT_SCHED_STRICT_PRIO_EN: requester 0 always wins ties
// (no round-robin pointer). Undefined: round-robin arbitration.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   reqN_valid/a/b, reqN_ready   requester N operand handshake (N=0,1)
//   clear                        empty both result regions
//   mult_input0/1, mult_product  multiplier operands / result
//   EN_writeMem, writeMem_addr/val  memory write port
//   region_full                  per-requester region full flags
//   state                        controller state (IDLE/BUSY/FULL)
module mult_sched #(
    parameter int LOGDEPTH = 6,
    parameter int WIDTH    = 32,
    parameter int LAT      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [15:0]         req0_a,
    input  logic [15:0]         req0_b,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [15:0]         req1_a,
    input  logic [15:0]         req1_b,
    output logic                req1_ready,
    input  logic                clear,
    output logic [15:0]         mult_input0,
    output logic [15:0]         mult_input1,
    input  logic [WIDTH-1:0]    mult_product,
    output logic                EN_writeMem,
    output logic [LOGDEPTH-1:0] writeMem_addr,
    output logic [WIDTH-1:0]    writeMem_val,
    output logic [1:0]          region_full,
    output logic [1:0]          state
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] FULL = 2'b10;

    localparam logic [LOGDEPTH-1:0] CAP = LOGDEPTH'(1 << (LOGDEPTH - 1));

    logic [LOGDEPTH-1:0] cnt0;
    logic [LOGDEPTH-1:0] cnt1;
    logic [LAT:0]        vld;
    logic [LOGDEPTH-1:0] adr [LAT+1];
    logic                elig0;
    logic                elig1;
    logic                gnt0;
    logic                gnt1;
    logic                accept;
    logic                busy_nxt;
    logic [LOGDEPTH-1:0] new_addr;
    logic [1:0]          state_nxt;

    assign region_full = {cnt1 == CAP, cnt0 == CAP};

    assign elig0 = req0_valid & ~region_full[0] & ~clear & ~rst;
    assign elig1 = req1_valid & ~region_full[1] & ~clear & ~rst;

`ifdef MULT_SCHED_STRICT_PRIO_EN
    assign gnt0 = elig0;
    assign gnt1 = elig1 & ~elig0;
`else
    // ptr high: requester 1 wins the next tie
    logic ptr;

    assign gnt0 = elig0 & (~elig1 | ~ptr);
    assign gnt1 = elig1 & (~elig0 | ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (gnt0 | gnt1) begin
            ptr <= gnt0;
        end
    end
`endif

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 | gnt1;

    // Region select in the MSB, fill count below it
    assign new_addr = gnt1 ? {1'b1, cnt1[LOGDEPTH-2:0]}
                           : {1'b0, cnt0[LOGDEPTH-2:0]};

    // Anything still in flight after this edge
    assign busy_nxt = accept | (|vld[LAT-1:0]);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = BUSY;
            BUSY: begin
                if (!busy_nxt) begin
                    state_nxt = (&region_full && !clear) ? FULL : IDLE;
                end
            end
            FULL: if (clear) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (clear) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (gnt0) cnt0 <= cnt0 + 1'b1;
            if (gnt1) cnt1 <= cnt1 + 1'b1;
        end
    end

    // vld[k]/adr[k] track the issue made k+1 cycles ago
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i <= LAT; i++) adr[i] <= '0;
        end else begin
            vld    <= {vld[LAT-1:0], accept};
            adr[0] <= new_addr;
            for (int i = 1; i <= LAT; i++) adr[i] <= adr[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mult_input0 <= '0;
            mult_input1 <= '0;
        end else if (gnt1) begin
            mult_input0 <= req1_a;
            mult_input1 <= req1_b;
        end else if (gnt0) begin
            mult_input0 <= req0_a;
            mult_input1 <= req0_b;
        end else begin
            mult_input0 <= '0;
            mult_input1 <= '0;
        end
    end

    // Product for the oldest issue is valid while vld[LAT] is set
    always_ff @(posedge clk) begin
        if (rst) begin
            EN_writeMem   <= 1'b0;
            writeMem_addr <= '0;
            writeMem_val  <= '0;
        end else begin
            EN_writeMem <= vld[LAT];
            if (vld[LAT]) begin
                writeMem_addr <= adr[LAT];
                writeMem_val  <= mult_product;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end
endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: randomized self-checking bench for mult_sched.
// A queue-based reference model predicts grants, writes and state.
module tb_mult_sched;
    localparam int LOGDEPTH = 6;
    localparam int WIDTH    = 32;
    localparam int LAT      = 4;
    localparam int HALF     = 1 << (LOGDEPTH - 1);
    localparam int OW       = 1 + LOGDEPTH + WIDTH + 2 + 2 + 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                req0_valid;
    logic [15:0]         req0_a;
    logic [15:0]         req0_b;
    logic                req0_ready;
    logic                req1_valid;
    logic [15:0]         req1_a;
    logic [15:0]         req1_b;
    logic                req1_ready;
    logic                clear;
    logic [15:0]         mult_input0;
    logic [15:0]         mult_input1;
    logic [WIDTH-1:0]    mult_product;
    logic                EN_writeMem;
    logic [LOGDEPTH-1:0] writeMem_addr;
    logic [WIDTH-1:0]    writeMem_val;
    logic [1:0]          region_full;
    logic [1:0]          state;

    mult_sched #(.LOGDEPTH(LOGDEPTH), .WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .clear(clear),
        .mult_input0(mult_input0), .mult_input1(mult_input1),
        .mult_product(mult_product),
        .EN_writeMem(EN_writeMem), .writeMem_addr(writeMem_addr),
        .writeMem_val(writeMem_val),
        .region_full(region_full), .state(state)
    );

    always #5 clk = ~clk;

    // Pipelined multiplier: product appears LAT cycles after operands
    logic [WIDTH-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= WIDTH'(mult_input0) * WIDTH'(mult_input1);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mult_product = mpipe[LAT-1];

    // Reference model
    typedef struct {
        int                  due;
        logic [LOGDEPTH-1:0] addr;
        logic [WIDTH-1:0]    val;
    } wr_t;

    wr_t q[$];
    int  cyc = 0;
    int  m_cnt0 = 0;
    int  m_cnt1 = 0;
    bit  m_pref = 1'b0;
    logic                e_en = 1'b0;
    logic [LOGDEPTH-1:0] e_addr = '0;
    logic [WIDTH-1:0]    e_val = '0;
    logic [15:0]         e_in0 = '0;
    logic [15:0]         e_in1 = '0;
    logic [1:0]          e_full = '0;
    logic [1:0]          e_state = '0;

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] c_rdy;
    logic [1:0] c_gnt;

    function automatic logic [1:0] model_grant();
        bit e0;
        bit e1;
        e0 = req0_valid && m_cnt0 < HALF && !clear && !rst;
        e1 = req1_valid && m_cnt1 < HALF && !clear && !rst;
        if (e0 && e1) begin
`ifdef MULT_SCHED_STRICT_PRIO_EN
            return 2'b01;
`else
            return m_pref ? 2'b10 : 2'b01;
`endif
        end
        return {e1, e0};
    endfunction

    always @(posedge clk) begin : model
        logic [1:0] g;
        g = model_grant();
        cyc++;
        if (rst) begin
            q.delete();
            m_cnt0 = 0; m_cnt1 = 0; m_pref = 1'b0;
            e_en = 1'b0; e_addr = '0; e_val = '0;
            e_in0 = '0; e_in1 = '0; e_full = '0; e_state = '0;
        end else begin
            e_en = 1'b0;
            if (q.size() != 0 && q[0].due == cyc) begin
                e_en = 1'b1;
                e_addr = q[0].addr;
                e_val = q[0].val;
                void'(q.pop_front());
            end
            e_in0 = '0;
            e_in1 = '0;
            if (g[0]) begin
                q.push_back('{cyc + LAT + 1, LOGDEPTH'(m_cnt0),
                              WIDTH'(req0_a) * WIDTH'(req0_b)});
                m_cnt0++; m_pref = 1'b1;
                e_in0 = req0_a; e_in1 = req0_b;
            end
            if (g[1]) begin
                q.push_back('{cyc + LAT + 1, LOGDEPTH'(HALF + m_cnt1),
                              WIDTH'(req1_a) * WIDTH'(req1_b)});
                m_cnt1++; m_pref = 1'b0;
                e_in0 = req1_a; e_in1 = req1_b;
            end
            if (clear) begin
                m_cnt0 = 0;
                m_cnt1 = 0;
            end
            e_full = {m_cnt1 == HALF, m_cnt0 == HALF};
            e_state = (q.size() != 0) ? 2'd1 : (&e_full ? 2'd2 : 2'd0);
        end
    end

    function automatic logic [OW-1:0] obs();
        return {EN_writeMem, writeMem_addr, writeMem_val, state,
                region_full, mult_input0, mult_input1};
    endfunction

    function automatic logic [OW-1:0] expv();
        return {e_en, e_addr, e_val, e_state, e_full, e_in0, e_in1};
    endfunction

    // Drive one cycle, sample ready before the edge, return at negedge
    task automatic step(input bit r, input bit v0, input bit v1,
                        input bit clr, input logic [15:0] a0,
                        input logic [15:0] b0, input logic [15:0] a1,
                        input logic [15:0] b1);
        rst = r; req0_valid = v0; req1_valid = v1; clear = clr;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        #1;
        c_rdy = {req1_ready, req0_ready};
        c_gnt = model_grant();
        @(negedge clk);
    endtask

    function automatic logic [15:0] rnd16();
        return 16'($urandom);
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 1, 1, rnd16(), rnd16(), rnd16(), rnd16());
            n_cmp++;
            if (c_rdy !== 2'b00) begin
                n_err++;
                $display("FAIL reset_ready got %b exp 00", c_rdy);
            end
            n_cmp++;
            if (obs() !== '0) begin
                n_err++;
                $display("FAIL reset_out got %h exp 0", obs());
            end
        end
    endtask

    task automatic test_single();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 16'd3, 16'd5, 0, 0);
        n_cmp++;
        if (mult_input0 !== 16'd3 || mult_input1 !== 16'd5) begin
            n_err++;
            $display("FAIL single_issue got %0d/%0d exp 3/5",
                     mult_input0, mult_input1);
        end
        for (int k = 2; k <= 7; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL single_out got %h exp %h", obs(), expv());
            end
            if (k == 6) begin
                n_cmp++;
                if (EN_writeMem !== 1'b1 || writeMem_addr !== 6'd0
                    || writeMem_val !== 32'd15) begin
                    n_err++;
                    $display("FAIL single_write got %b/%0d/%0d exp 1/0/15",
                             EN_writeMem, writeMem_addr, writeMem_val);
                end
            end
        end
    endtask

    task automatic test_alternate();
        int wa[$];
        int wc[$];
        int exp_a[8] = '{0, 32, 1, 33, 2, 34, 3, 35};
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, i < 8, i < 8, 0, rnd16(), rnd16(), rnd16(), rnd16());
            n_cmp++;
            if (c_rdy !== c_gnt) begin
                n_err++;
                $display("FAIL alt_ready got %b exp %b", c_rdy, c_gnt);
            end
`ifndef MULT_SCHED_STRICT_PRIO_EN
            if (i < 8) begin
                n_cmp++;
                if (c_rdy !== ((i % 2) ? 2'b10 : 2'b01)) begin
                    n_err++;
                    $display("FAIL alt_order cycle %0d got %b", i, c_rdy);
                end
            end
`endif
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL alt_out got %h exp %h", obs(), expv());
            end
            if (EN_writeMem) begin
                wa.push_back(int'(writeMem_addr));
                wc.push_back(cyc);
            end
        end
`ifndef MULT_SCHED_STRICT_PRIO_EN
        n_cmp++;
        if (wa.size() != 8) begin
            n_err++;
            $display("FAIL alt_count got %0d exp 8", wa.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (wa[i] != exp_a[i] || wc[i] != wc[0] + i) begin
                    n_err++;
                    $display("FAIL alt_addr %0d got %0d@%0d exp %0d@%0d",
                             i, wa[i], wc[i], exp_a[i], wc[0] + i);
                end
            end
        end
`endif
    endtask

    task automatic test_fill();
        int last0 = -1;
        int first1 = -1;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // 33 req0 cycles, then 32 with both valid, then drain
        for (int i = 0; i < 33 + 32 + 8; i++) begin
            step(0, i < 65, i >= 33 && i < 65, 0,
                 rnd16(), rnd16(), rnd16(), rnd16());
            n_cmp++;
            if (c_rdy !== c_gnt) begin
                n_err++;
                $display("FAIL fill_ready got %b exp %b", c_rdy, c_gnt);
            end
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL fill_out got %h exp %h", obs(), expv());
            end
            if (EN_writeMem && writeMem_addr < 6'd32) last0 = int'(writeMem_addr);
            if (i == 32 || i == 33) begin
                n_cmp++;
                if (c_rdy !== ((i == 32) ? 2'b00 : 2'b10)
                    || region_full[0] !== 1'b1) begin
                    n_err++;
                    $display("FAIL fill_full0 cycle %0d got %b/%b", i,
                             c_rdy, region_full);
                end
            end
            if (i == 64) begin
                n_cmp++;
                if (state !== 2'b01 || region_full !== 2'b11) begin
                    n_err++;
                    $display("FAIL fill_busy got %b/%b exp 01/11",
                             state, region_full);
                end
            end
        end
        n_cmp++;
        if (state !== 2'b10 || last0 != 31) begin
            n_err++;
            $display("FAIL fill_drain got state %b last %0d exp 10/31",
                     state, last0);
        end
        step(0, 1, 1, 1, 0, 0, 0, 0);
        n_cmp++;
        if (c_rdy !== 2'b00 || state !== 2'b00 || region_full !== 2'b00) begin
            n_err++;
            $display("FAIL fill_clear got %b/%b/%b exp 00/00/00",
                     c_rdy, state, region_full);
        end
        step(0, 0, 1, 0, rnd16(), rnd16(), 16'd7, 16'd9);
        for (int k = 0; k < 7; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL refill_out got %h exp %h", obs(), expv());
            end
            if (EN_writeMem && first1 < 0) first1 = int'(writeMem_addr);
        end
        n_cmp++;
        if (first1 != 32) begin
            n_err++;
            $display("FAIL refill_addr got %0d exp 32", first1);
        end
    endtask

    task automatic test_clear_inflight();
        bit saw5 = 1'b0;
        int lastw = -1;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // accepts 0..5, clear two cycles after addr 5, then one more
        for (int i = 0; i < 18; i++) begin
            step(0, i < 6 || i == 10, 0, i == 7,
                 rnd16(), rnd16(), 0, 0);
            n_cmp++;
            if (c_rdy !== c_gnt) begin
                n_err++;
                $display("FAIL clr_ready got %b exp %b", c_rdy, c_gnt);
            end
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL clr_out got %h exp %h", obs(), expv());
            end
            if (EN_writeMem) begin
                if (writeMem_addr == 6'd5) saw5 = 1'b1;
                lastw = int'(writeMem_addr);
            end
        end
        n_cmp++;
        if (!saw5 || lastw != 0) begin
            n_err++;
            $display("FAIL clr_addr got saw5=%0d last=%0d exp 1/0",
                     saw5, lastw);
        end
    endtask

    task automatic test_reset_inflight();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, rnd16(), rnd16(), rnd16(), rnd16());
        end
        step(1, 1, 1, 0, rnd16(), rnd16(), rnd16(), rnd16());
        n_cmp++;
        if (obs() !== '0 || c_rdy !== 2'b00) begin
            n_err++;
            $display("FAIL rstfl_out got %h/%b exp 0/00", obs(), c_rdy);
        end
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0);
            n_cmp++;
            if (EN_writeMem !== 1'b0 || obs() !== expv()) begin
                n_err++;
                $display("FAIL rstfl_write got %h exp %h", obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 99) < 3,
                 rnd16(), rnd16(), rnd16(), rnd16());
            n_cmp++;
            if (c_rdy !== c_gnt) begin
                n_err++;
                $display("FAIL rand_ready got %b exp %b", c_rdy, c_gnt);
            end
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL rand_out got %h exp %h", obs(), expv());
            end
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_alternate();
        test_fill();
        test_clear_inflight();
        test_reset_inflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
